// File: rtl/pll_sup_pkg.sv
// Shared types and helpers for the PLL lock supervisor.
package pll_sup_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RESET     = 3'd1,
        ST_WAIT_LOCK = 3'd2,
        ST_STABLE    = 3'd3,
        ST_READY     = 3'd4,
        ST_FAULT     = 3'd5
    } state_t;

    // Bits needed to hold any value 0..max_val, never less than one.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/bit_sync.sv
// N-flop level synchronizer with synchronous active-high reset (clears to 0).
module bit_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;

    // Shift the asynchronous input through the flop chain.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d};
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/pll_lock_supervisor.sv
// PLL reset / lock handshake sequencer running on the reference clock.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   IDLE      | disabled, PLL held in reset
//   RESET     | PLL reset pulse of RESET_CYCLES cycles
//   WAIT_LOCK | reset released, waiting for lock with a timeout
//   STABLE    | locked, counting consecutive locked cycles
//   READY     | output clock trusted, clk_ready asserted
//   FAULT     | retries exhausted, PLL held in reset until relock_req
module pll_lock_supervisor
    import pll_sup_pkg::*;
#(
    parameter int RESET_CYCLES  = 16,
    parameter int LOCK_TIMEOUT  = 50000,
    parameter int STABLE_CYCLES = 1024,
    parameter int MAX_RETRIES   = 3,
    parameter int SYNC_STAGES   = 2
) (
    input  logic                               refclk,
    input  logic                               rst,
    input  logic                               enable,
    input  logic                               relock_req,
    input  logic                               pll_locked,
    output logic                               pll_rst,
    output logic                               clk_ready,
    output logic                               lock_lost,
    output logic                               fault,
    output logic [$clog2(MAX_RETRIES+1)-1:0]   retry_count,
    output logic [2:0]                         state
);

    localparam int RW = cnt_width(RESET_CYCLES);
    localparam int TW = cnt_width(LOCK_TIMEOUT);
    localparam int SW = cnt_width(STABLE_CYCLES);
    localparam int CW = $clog2(MAX_RETRIES + 1);

    // Timers are down-counters loaded on state entry; the terminal cycle is
    // the one in which the counter reads zero, so each load is N-1.
    localparam logic [RW-1:0] RST_LOAD  = RW'(RESET_CYCLES - 1);
    localparam logic [TW-1:0] TO_LOAD   = TW'(LOCK_TIMEOUT - 1);
    localparam logic [SW-1:0] STB_LOAD  = SW'(STABLE_CYCLES - 1);
    localparam logic [CW-1:0] RETRY_MAX = CW'(MAX_RETRIES);

    state_t          state_q, state_d;
    logic [RW-1:0]   rst_cnt_q, rst_cnt_d;
    logic [TW-1:0]   to_cnt_q, to_cnt_d;
    logic [SW-1:0]   stb_cnt_q, stb_cnt_d;
    logic [CW-1:0]   retry_q, retry_d, retry_inc;
    logic            lk;
    logic            pll_rst_d, clk_ready_d, lock_lost_d, fault_d;

    bit_sync #(
        .STAGES (SYNC_STAGES)
    ) u_lock_sync (
        .clk (refclk),
        .rst (rst),
        .d   (pll_locked),
        .q   (lk)
    );

    assign retry_inc = (retry_q == RETRY_MAX) ? retry_q : retry_q + CW'(1);

    // State, counter and output registers.
    always_ff @(posedge refclk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            rst_cnt_q <= '0;
            to_cnt_q  <= '0;
            stb_cnt_q <= '0;
            retry_q   <= '0;
            pll_rst   <= 1'b1;
            clk_ready <= 1'b0;
            lock_lost <= 1'b0;
            fault     <= 1'b0;
        end else begin
            state_q   <= state_d;
            rst_cnt_q <= rst_cnt_d;
            to_cnt_q  <= to_cnt_d;
            stb_cnt_q <= stb_cnt_d;
            retry_q   <= retry_d;
            pll_rst   <= pll_rst_d;
            clk_ready <= clk_ready_d;
            lock_lost <= lock_lost_d;
            fault     <= fault_d;
        end
    end

    // Next-state and counter logic; enable and relock_req override lock events.
    always_comb begin
        state_d   = state_q;
        rst_cnt_d = rst_cnt_q;
        to_cnt_d  = to_cnt_q;
        stb_cnt_d = stb_cnt_q;
        retry_d   = retry_q;

        if (!enable) begin
            state_d = ST_IDLE;
            retry_d = '0;
        end else if (relock_req) begin
            state_d   = ST_RESET;
            rst_cnt_d = RST_LOAD;
            if (state_q == ST_FAULT) begin
                retry_d = '0;
            end
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    state_d   = ST_RESET;
                    rst_cnt_d = RST_LOAD;
                end
                ST_RESET: begin
                    if (rst_cnt_q == '0) begin
                        state_d  = ST_WAIT_LOCK;
                        to_cnt_d = TO_LOAD;
                    end else begin
                        rst_cnt_d = rst_cnt_q - RW'(1);
                    end
                end
                ST_WAIT_LOCK: begin
                    // A lock seen on the expiry cycle still wins.
                    if (lk) begin
                        state_d   = ST_STABLE;
                        stb_cnt_d = STB_LOAD;
                    end else if (to_cnt_q == '0) begin
                        retry_d = retry_inc;
                        if (retry_inc == RETRY_MAX) begin
                            state_d = ST_FAULT;
                        end else begin
                            state_d   = ST_RESET;
                            rst_cnt_d = RST_LOAD;
                        end
                    end else begin
                        to_cnt_d = to_cnt_q - TW'(1);
                    end
                end
                ST_STABLE: begin
                    // A glitch restarts the lock wait but is not a failed attempt.
                    if (!lk) begin
                        state_d  = ST_WAIT_LOCK;
                        to_cnt_d = TO_LOAD;
                    end else if (stb_cnt_q == '0) begin
                        state_d = ST_READY;
                        retry_d = '0;
                    end else begin
                        stb_cnt_d = stb_cnt_q - SW'(1);
                    end
                end
                ST_READY: begin
                    if (!lk) begin
                        state_d   = ST_RESET;
                        rst_cnt_d = RST_LOAD;
                    end
                end
                ST_FAULT: begin
                    state_d = ST_FAULT;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Output values registered alongside the state they belong to.
    always_comb begin
        pll_rst_d   = (state_d == ST_IDLE) || (state_d == ST_RESET) || (state_d == ST_FAULT);
        clk_ready_d = (state_d == ST_READY);
        fault_d     = (state_d == ST_FAULT);
        lock_lost_d = (state_q == ST_READY) && enable && !relock_req && !lk;
    end

    assign retry_count = retry_q;
    assign state       = state_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed self-checking bench for pll_lock_supervisor with small parameters.
module tb_pll_lock_supervisor;

    localparam int RESET_CYCLES  = 4;
    localparam int LOCK_TIMEOUT  = 20;
    localparam int STABLE_CYCLES = 8;
    localparam int MAX_RETRIES   = 2;
    localparam int SYNC_STAGES   = 2;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_RESET  = 3'd1;
    localparam logic [2:0] S_WAIT   = 3'd2;
    localparam logic [2:0] S_STABLE = 3'd3;
    localparam logic [2:0] S_READY  = 3'd4;
    localparam logic [2:0] S_FAULT  = 3'd5;

    logic       refclk;
    logic       rst;
    logic       enable;
    logic       relock_req;
    logic       pll_locked;
    logic       pll_rst;
    logic       clk_ready;
    logic       lock_lost;
    logic       fault;
    logic [1:0] retry_count;
    logic [2:0] state;

    int checks = 0;
    int errors = 0;

    pll_lock_supervisor #(
        .RESET_CYCLES  (RESET_CYCLES),
        .LOCK_TIMEOUT  (LOCK_TIMEOUT),
        .STABLE_CYCLES (STABLE_CYCLES),
        .MAX_RETRIES   (MAX_RETRIES),
        .SYNC_STAGES   (SYNC_STAGES)
    ) dut (
        .refclk      (refclk),
        .rst         (rst),
        .enable      (enable),
        .relock_req  (relock_req),
        .pll_locked  (pll_locked),
        .pll_rst     (pll_rst),
        .clk_ready   (clk_ready),
        .lock_lost   (lock_lost),
        .fault       (fault),
        .retry_count (retry_count),
        .state       (state)
    );

    initial refclk = 1'b0;
    always #10 refclk = ~refclk;

    // Inputs are driven and outputs sampled on the falling edge.
    task automatic step(input int n);
        repeat (n) @(negedge refclk);
    endtask

    // Number of consecutive falling-edge samples spent in state s (bounded).
    task automatic run_len(input logic [2:0] s, output int n);
        n = 0;
        while (state == s && n < 100) begin
            n++;
            step(1);
        end
    endtask

    // Cycles until clk_ready rises (bounded).
    task automatic wait_ready(output int n);
        n = 0;
        while (!clk_ready && n < 60) begin
            n++;
            step(1);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; enable = 1'b0; relock_req = 1'b0; pll_locked = 1'b0;
        step(2);
        checks++; if (state !== S_IDLE) begin errors++; $display("FAIL reset_state got %0d want %0d", state, S_IDLE); end
        checks++; if ({pll_rst, clk_ready, lock_lost, fault} !== 4'b1000) begin errors++; $display("FAIL reset_outputs got %b want 1000", {pll_rst, clk_ready, lock_lost, fault}); end
        checks++; if (retry_count !== 2'd0) begin errors++; $display("FAIL reset_retry got %0d want 0", retry_count); end
        rst = 1'b0;
        step(3);
        checks++; if (state !== S_IDLE || pll_rst !== 1'b1) begin errors++; $display("FAIL idle_disabled got state %0d pll_rst %b want 0/1", state, pll_rst); end
    endtask

    task automatic test_nominal();
        int n;
        enable = 1'b1;
        step(1);
        run_len(S_RESET, n);
        checks++; if (n != 4) begin errors++; $display("FAIL nom_reset_len got %0d want 4", n); end
        checks++; if (state !== S_WAIT || pll_rst !== 1'b0) begin errors++; $display("FAIL nom_wait got state %0d pll_rst %b want 2/0", state, pll_rst); end
        step(4);
        pll_locked = 1'b1;
        wait_ready(n);
        checks++; if (n != 11) begin errors++; $display("FAIL nom_ready_latency got %0d want 11", n); end
        checks++; if (state !== S_READY || retry_count !== 2'd0 || pll_rst !== 1'b0) begin errors++; $display("FAIL nom_ready got state %0d retry %0d pll_rst %b want 4/0/0", state, retry_count, pll_rst); end
    endtask

    task automatic test_loss_of_lock();
        int n;
        pll_locked = 1'b0;
        step(2);
        checks++; if (clk_ready !== 1'b1 || lock_lost !== 1'b0) begin errors++; $display("FAIL lol_early got ready %b lost %b want 1/0", clk_ready, lock_lost); end
        step(1);
        checks++; if (clk_ready !== 1'b0 || lock_lost !== 1'b1 || pll_rst !== 1'b1 || state !== S_RESET) begin errors++; $display("FAIL lol_edge got ready %b lost %b pll_rst %b state %0d want 0/1/1/1", clk_ready, lock_lost, pll_rst, state); end
        step(1);
        checks++; if (lock_lost !== 1'b0 || retry_count !== 2'd0) begin errors++; $display("FAIL lol_pulse got lost %b retry %0d want 0/0", lock_lost, retry_count); end
        run_len(S_RESET, n);
        // three more RESET samples after the one at the lock_lost cycle
        checks++; if (n != 3) begin errors++; $display("FAIL lol_reset_len got %0d want 3", n); end
        pll_locked = 1'b1;
        wait_ready(n);
        checks++; if (n != 11 || clk_ready !== 1'b1) begin errors++; $display("FAIL lol_relock got %0d want 11", n); end
    endtask

    task automatic test_glitch();
        int n;
        relock_req = 1'b1;
        step(1);
        relock_req = 1'b0;
        checks++; if (state !== S_RESET || lock_lost !== 1'b0 || clk_ready !== 1'b0) begin errors++; $display("FAIL relock_ready got state %0d lost %b ready %b want 1/0/0", state, lock_lost, clk_ready); end
        n = 0;
        while (state !== S_STABLE && n < 40) begin n++; step(1); end
        checks++; if (n != 5) begin errors++; $display("FAIL gl_to_stable got %0d want 5", n); end
        step(3);
        pll_locked = 1'b0;
        step(1);
        pll_locked = 1'b1;
        step(1);
        checks++; if (state !== S_STABLE) begin errors++; $display("FAIL gl_still_stable got %0d want 3", state); end
        step(1);
        checks++; if (state !== S_WAIT || retry_count !== 2'd0) begin errors++; $display("FAIL gl_back_wait got state %0d retry %0d want 2/0", state, retry_count); end
        wait_ready(n);
        checks++; if (n != 9) begin errors++; $display("FAIL gl_ready_latency got %0d want 9", n); end
    endtask

    task automatic test_timeout_fault();
        int n;
        pll_locked = 1'b0;
        enable = 1'b0;
        step(1);
        checks++; if (state !== S_IDLE || clk_ready !== 1'b0 || pll_rst !== 1'b1 || lock_lost !== 1'b0) begin errors++; $display("FAIL en_drop_ready got state %0d ready %b pll_rst %b lost %b want 0/0/1/0", state, clk_ready, pll_rst, lock_lost); end
        enable = 1'b1;
        step(1);
        run_len(S_RESET, n);
        checks++; if (n != 4) begin errors++; $display("FAIL to_reset1 got %0d want 4", n); end
        run_len(S_WAIT, n);
        checks++; if (n != 20) begin errors++; $display("FAIL to_wait1 got %0d want 20", n); end
        checks++; if (state !== S_RESET || retry_count !== 2'd1) begin errors++; $display("FAIL to_retry1 got state %0d retry %0d want 1/1", state, retry_count); end
        run_len(S_RESET, n);
        checks++; if (n != 4) begin errors++; $display("FAIL to_reset2 got %0d want 4", n); end
        run_len(S_WAIT, n);
        checks++; if (n != 20) begin errors++; $display("FAIL to_wait2 got %0d want 20", n); end
        checks++; if (state !== S_FAULT || fault !== 1'b1 || retry_count !== 2'd2 || pll_rst !== 1'b1) begin errors++; $display("FAIL to_fault got state %0d fault %b retry %0d pll_rst %b want 5/1/2/1", state, fault, retry_count, pll_rst); end
        pll_locked = 1'b1;
        step(6);
        checks++; if (state !== S_FAULT || fault !== 1'b1 || pll_rst !== 1'b1) begin errors++; $display("FAIL fault_sticky got state %0d fault %b pll_rst %b want 5/1/1", state, fault, pll_rst); end
        relock_req = 1'b1;
        step(1);
        relock_req = 1'b0;
        checks++; if (state !== S_RESET || fault !== 1'b0 || retry_count !== 2'd0 || pll_rst !== 1'b1) begin errors++; $display("FAIL fault_clear got state %0d fault %b retry %0d pll_rst %b want 1/0/0/1", state, fault, retry_count, pll_rst); end
        run_len(S_RESET, n);
        checks++; if (n != 4) begin errors++; $display("FAIL fault_reset_len got %0d want 4", n); end
        wait_ready(n);
        checks++; if (clk_ready !== 1'b1 || n != 9) begin errors++; $display("FAIL fault_recover got %0d want 9", n); end
    endtask

    task automatic test_enable_drop();
        int n;
        pll_locked = 1'b0;
        relock_req = 1'b1;
        step(1);
        relock_req = 1'b0;
        run_len(S_RESET, n);
        run_len(S_WAIT, n);
        checks++; if (n != 20 || retry_count !== 2'd1) begin errors++; $display("FAIL ed_retry got wait %0d retry %0d want 20/1", n, retry_count); end
        run_len(S_RESET, n);
        step(5);
        checks++; if (state !== S_WAIT || retry_count !== 2'd1) begin errors++; $display("FAIL ed_mid_wait got state %0d retry %0d want 2/1", state, retry_count); end
        enable = 1'b0;
        step(1);
        checks++; if (state !== S_IDLE || pll_rst !== 1'b1 || retry_count !== 2'd0 || fault !== 1'b0) begin errors++; $display("FAIL ed_idle got state %0d pll_rst %b retry %0d fault %b want 0/1/0/0", state, pll_rst, retry_count, fault); end
        step(2);
        enable = 1'b1;
        pll_locked = 1'b1;
        step(1);
        run_len(S_RESET, n);
        checks++; if (n != 4) begin errors++; $display("FAIL ed_reset_len got %0d want 4", n); end
        wait_ready(n);
        checks++; if (n != 9 || retry_count !== 2'd0) begin errors++; $display("FAIL ed_ready got %0d retry %0d want 9/0", n, retry_count); end
    endtask

    task automatic test_reset_ready();
        checks++; if (state !== S_READY) begin errors++; $display("FAIL rr_precond got %0d want 4", state); end
        rst = 1'b1;
        pll_locked = 1'b0;
        step(1);
        checks++; if (state !== S_IDLE || {pll_rst, clk_ready, lock_lost, fault} !== 4'b1000 || retry_count !== 2'd0) begin errors++; $display("FAIL rr_outputs got state %0d outs %b retry %0d want 0/1000/0", state, {pll_rst, clk_ready, lock_lost, fault}, retry_count); end
        step(1);
        rst = 1'b0;
    endtask

    task automatic test_simultaneous();
        int n;
        step(1);
        run_len(S_RESET, n);
        checks++; if (n != 4) begin errors++; $display("FAIL sim_reset_len got %0d want 4", n); end
        step(17);
        pll_locked = 1'b1;
        step(2);
        checks++; if (state !== S_WAIT) begin errors++; $display("FAIL sim_last_wait got %0d want 2", state); end
        step(1);
        checks++; if (state !== S_STABLE || retry_count !== 2'd0) begin errors++; $display("FAIL sim_lock_wins got state %0d retry %0d want 3/0", state, retry_count); end
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; relock_req = 1'b0; pll_locked = 1'b0;
        test_reset();
        test_nominal();
        test_loss_of_lock();
        test_glitch();
        test_timeout_fault();
        test_enable_drop();
        test_reset_ready();
        test_simultaneous();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pll_lock_supervisor.md
# pll_lock_supervisor

Sequences the reset and lock handshake of the 50 MHz→670 MHz overclock PLL and tells downstream logic when the PLL output clock can be trusted. Runs entirely on the 50 MHz reference clock. Drives the PLL reset, samples the PLL `locked` flag through a synchronizer and requires lock to stay stable before asserting `clk_ready`. Retries on lock timeout, reports a sticky fault after repeated failures, and re-sequences automatically on loss of lock.

## Interface
- `RESET_CYCLES`, 16: width of the PLL reset pulse, in refclk cycles (≥1).
- `LOCK_TIMEOUT`, 50000: refclk cycles allowed for lock after reset release (1 ms at 50 MHz).
- `STABLE_CYCLES`, 1024: consecutive synchronized-locked cycles required before ready.
- `MAX_RETRIES`, 3: failed lock attempts before entering FAULT (≥1).
- `SYNC_STAGES`, 2: flops in the `pll_locked` synchronizer (≥2).

Ports:
- `refclk` in 1: free-running 50 MHz reference clock; the only clock.
- `rst` in 1: synchronous, active-high reset.
- `enable` in 1: level; 1 = bring up the PLL, 0 = hold the PLL in reset.
- `relock_req` in 1: single-cycle request to re-sequence; also the only exit from FAULT.
- `pll_locked` in 1: raw PLL `locked` flag; asynchronous to refclk.
- `pll_rst` out 1: reset to the PLL, active-high.
- `clk_ready` out 1: PLL output clock is locked and stable.
- `lock_lost` out 1: one-cycle pulse when lock drops while in READY.
- `fault` out 1: sticky; retries are exhausted.
- `retry_count` out `$clog2(MAX_RETRIES+1)`: failed attempts since the last success or clear.
- `state` out 3: current FSM state encoding, for debug.

## Operation
- All outputs are registered.
- Reset values: state IDLE, `pll_rst`=1, `clk_ready`=0, `lock_lost`=0, `fault`=0, `retry_count`=0. The synchronizer is cleared to 0.
- `lk` denotes the output of the `pll_locked` synchronizer.
- **IDLE**: `pll_rst`=1. `enable`=1 moves to RESET.
- **RESET**: `pll_rst`=1 for exactly `RESET_CYCLES` cycles, then moves to WAIT_LOCK. The cycle counter is cleared on entry.
- **WAIT_LOCK**: `pll_rst`=0 and the timeout counter runs.
  - `lk`=1: move to STABLE.
  - Counter reaches `LOCK_TIMEOUT` with no lock: increment `retry_count`. If the new value equals `MAX_RETRIES`, move to FAULT; otherwise move to RESET.
- **STABLE**: `pll_rst`=0 and the stable counter counts cycles with `lk`=1.
  - `lk`=0: return to WAIT_LOCK with the timeout counter restarted. The glitch does not count as a retry.
  - Count reaches `STABLE_CYCLES`: move to READY and clear `retry_count`.
- **READY**: `clk_ready`=1.
  - `lk`=0: pulse `lock_lost` for one cycle, deassert `clk_ready`, move to RESET. `retry_count` stays 0.
  - `relock_req`=1: move to RESET without pulsing `lock_lost`.
- **FAULT**: `pll_rst`=1, `fault`=1.
  - `relock_req`=1: clear `fault` and `retry_count`, move to RESET.
  - `pll_locked` is ignored.
- Priority in every state: `rst` > `enable`=0 > `relock_req` > lock/timeout events.
  - `enable`=0 in any state moves to IDLE next cycle. `fault`, `clk_ready` and `retry_count` clear, and `pll_rst`=1.
- `relock_req` in IDLE, RESET or WAIT_LOCK restarts RESET from cycle 0 (WAIT_LOCK abandons the attempt). In STABLE it has the same effect.
- Counters saturate and never wrap. Counter widths are `$clog2(param+1)`.

## Timing
- `pll_locked` rising reaches `lk` after `SYNC_STAGES` cycles.
- Minimum latency from `pll_locked` rising in WAIT_LOCK to `clk_ready`=1 is `SYNC_STAGES + STABLE_CYCLES + 1` cycles.
- `pll_locked` falling in READY: `clk_ready` drops and `lock_lost` pulses `SYNC_STAGES + 1` cycles later, in the same cycle. `pll_rst` rises in that cycle too.
- `enable` 1→0: `pll_rst`=1 and `clk_ready`=0 on the next refclk edge.
- Lock arriving in the same cycle the timeout expires: lock wins, no retry is counted.
- `rst` asserted mid-sequence returns all outputs to their reset values on the next edge, regardless of state.

## Structure
- Package `pll_sup_pkg` holds:
  - the state enum: IDLE=0, RESET=1, WAIT_LOCK=2, STABLE=3, READY=4, FAULT=5;
  - a `clog2`-based width helper used for the counter widths.
- Sub-module `bit_sync`: an N-flop synchronizer with synchronous reset, parameter `STAGES`, instantiated once for `pll_locked`.
- Everything else lives in a single FSM and counter process plus registered output logic.

## Test plan
All scenarios use `RESET_CYCLES=4`, `LOCK_TIMEOUT=20`, `STABLE_CYCLES=8`, `MAX_RETRIES=2`, `SYNC_STAGES=2`.
- **Nominal bring-up**: release `rst`, hold `enable`=1, raise `pll_locked` 5 cycles after `pll_rst` falls. Expect `pll_rst`=1 for 4 cycles and `clk_ready`=1 exactly 11 cycles after `pll_locked` rises, with `retry_count`=0.
- **Timeout and fault**: keep `pll_locked`=0. Expect two RESET pulses of 4 cycles separated by 20 cycles of WAIT_LOCK, `retry_count` going 1 then 2, then `fault`=1 and `pll_rst`=1 held. Then `relock_req` pulse: expect `fault`=0, `retry_count`=0, and a new 4-cycle reset.
- **Lock glitch in STABLE**: drop `pll_locked` for 1 cycle at stable count 5. Expect a return to WAIT_LOCK, no retry increment, and `clk_ready` only after 8 further uninterrupted locked cycles.
- **Loss of lock in READY**: drop `pll_locked`. Expect `lock_lost` as a single pulse and `clk_ready`=0 3 cycles later, followed by a new 4-cycle `pll_rst` and re-lock to ready.
- **Enable drop mid-WAIT_LOCK with `retry_count`=1**: expect IDLE next cycle, `pll_rst`=1, `retry_count`=0. Re-enable: a full sequence with no residual state.
- **Reset mid-READY and simultaneous events**: assert `rst` in READY and expect all outputs at their reset values next edge. Separately, assert lock on the timeout cycle and expect STABLE with no retry counted.
